// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the x0 register index and the
// width of the stall/flush down-counter, plus a saturating increment used
// by the optional performance counters (PIPELINE_PERF_COUNTERS_EN).
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_STALL  = 2'd1,
        FLUSH       = 2'd2,
        STDOUT_WAIT = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 4;
    localparam int         PERF_CNT_W  = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [PERF_CNT_W-1:0] satInc(input logic [PERF_CNT_W-1:0] value);
        satInc = (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use hazard detector: flags when the instruction in EX is a load
// whose destination is a source that the ID instruction actually reads.
// Writes to x0 never create a hazard because x0 is hardwired to zero.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1_address,
    input  logic [4:0] i_id_rs2_address,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd_address,
    input  logic       i_ex_reg_write_enable,
    input  logic       i_ex_is_load,
    output logic       o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_load_writes_reg;

    // Compare each used source against the pending load destination.
    always_comb begin
        w_rs1_match       = i_id_rs1_used & (i_id_rs1_address == i_ex_rd_address);
        w_rs2_match       = i_id_rs2_used & (i_id_rs2_address == i_ex_rd_address);
        w_load_writes_reg = i_ex_is_load & i_ex_reg_write_enable & (i_ex_rd_address != REG_ZERO);
        o_hazard          = w_load_writes_reg & (w_rs1_match | w_rs2_match);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage core.
// Produces the pipeline-register write enables, the IF/ID flush and the
// ID/EX bubble from load-use hazards, EX-resolved redirects and stdout
// back-pressure. Priority: stdout freeze > redirect > load-use.
// Optional macro PIPELINE_PERF_COUNTERS_EN adds saturating 32-bit counters
// of load-stall, flush and stdout-wait cycles.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES          = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_address,
    input  logic [4:0] id_rs2_address,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd_address,
    input  logic       ex_reg_write_enable,
    input  logic       ex_is_load,
    input  logic       ex_redirect,
    input  logic       ex_stdout_write_enable,
    input  logic       stdout_busy,
    output logic       pc_write_enable,
    output logic       if_id_write_enable,
    output logic       if_id_flush,
    output logic       id_ex_write_enable,
    output logic       id_ex_bubble,
    output logic       ex_mem_write_enable,
    output logic [1:0] ctrl_state
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    output logic [31:0] load_stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] stdout_wait_count
`endif
);

    // The first stall/flush cycle is spent in RUN, so the counter is loaded
    // with (cycles - 2) and counts down to zero inclusive.
    localparam int LOAD_RELOAD_INT  = (LOAD_USE_STALL_CYCLES > 1) ? LOAD_USE_STALL_CYCLES - 2 : 0;
    localparam int FLUSH_RELOAD_INT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
    localparam logic [STALL_CNT_W-1:0] LOAD_RELOAD  = STALL_CNT_W'(LOAD_RELOAD_INT);
    localparam logic [STALL_CNT_W-1:0] FLUSH_RELOAD = STALL_CNT_W'(FLUSH_RELOAD_INT);

    ctrl_state_t            r_state;
    logic [STALL_CNT_W-1:0] r_cnt;

    ctrl_state_t            w_next_state;
    logic [STALL_CNT_W-1:0] w_next_cnt;
    logic                   w_hazard;
    logic                   w_freeze;
    logic                   w_pc_we;
    logic                   w_if_id_we;
    logic                   w_if_id_flush;
    logic                   w_id_ex_we;
    logic                   w_id_ex_bubble;
    logic                   w_ex_mem_we;

    load_use_detector u_load_use_detector (
        .i_id_rs1_address      (id_rs1_address),
        .i_id_rs2_address      (id_rs2_address),
        .i_id_rs1_used         (id_rs1_used),
        .i_id_rs2_used         (id_rs2_used),
        .i_ex_rd_address       (ex_rd_address),
        .i_ex_reg_write_enable (ex_reg_write_enable),
        .i_ex_is_load          (ex_is_load),
        .o_hazard              (w_hazard)
    );

    assign w_freeze = ex_stdout_write_enable & stdout_busy;

    // Output decode and next-state selection from the current state and inputs.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_pc_we        = 1'b1;
        w_if_id_we     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_we     = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_we    = 1'b1;
        unique case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_pc_we      = 1'b0;
                    w_if_id_we   = 1'b0;
                    w_id_ex_we   = 1'b0;
                    w_ex_mem_we  = 1'b0;
                    w_next_state = STDOUT_WAIT;
                end else if (ex_redirect) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = FLUSH;
                        w_next_cnt   = FLUSH_RELOAD;
                    end
                end else if (w_hazard) begin
                    w_pc_we        = 1'b0;
                    w_if_id_we     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    if (LOAD_USE_STALL_CYCLES > 1) begin
                        w_next_state = LOAD_STALL;
                        w_next_cnt   = LOAD_RELOAD;
                    end
                end
            end
            LOAD_STALL: begin
                w_pc_we        = 1'b0;
                w_if_id_we     = 1'b0;
                w_id_ex_bubble = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = RUN;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            FLUSH: begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = RUN;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            STDOUT_WAIT: begin
                if (stdout_busy) begin
                    w_pc_we     = 1'b0;
                    w_if_id_we  = 1'b0;
                    w_id_ex_we  = 1'b0;
                    w_ex_mem_we = 1'b0;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Reset forces every enable, flush and bubble low so nothing is captured.
    always_comb begin
        pc_write_enable     = w_pc_we        & ~reset;
        if_id_write_enable  = w_if_id_we     & ~reset;
        if_id_flush         = w_if_id_flush  & ~reset;
        id_ex_write_enable  = w_id_ex_we     & ~reset;
        id_ex_bubble        = w_id_ex_bubble & ~reset;
        ex_mem_write_enable = w_ex_mem_we    & ~reset;
        ctrl_state          = reset ? 2'd0 : r_state;
    end

    // State and down-counter registers; reset lands in RUN with no pending stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic        w_stdout_cyc;
    logic        w_load_cyc;
    logic [31:0] r_load_stall_count;
    logic [31:0] r_flush_count;
    logic [31:0] r_stdout_wait_count;

    // Attribute each lost cycle to the single cause that owns it.
    always_comb begin
        w_stdout_cyc = ~pc_write_enable &
                       ((r_state == STDOUT_WAIT) | ((r_state == RUN) & w_freeze));
        w_load_cyc   = ~pc_write_enable & ~w_stdout_cyc &
                       ((r_state == LOAD_STALL) | (r_state == RUN));
    end

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_stall_count  <= '0;
            r_flush_count       <= '0;
            r_stdout_wait_count <= '0;
        end else begin
            if (w_load_cyc)   r_load_stall_count  <= satInc(r_load_stall_count);
            if (if_id_flush)  r_flush_count       <= satInc(r_flush_count);
            if (w_stdout_cyc) r_stdout_wait_count <= satInc(r_stdout_wait_count);
        end
    end

    assign load_stall_count  = r_load_stall_count;
    assign flush_count       = r_flush_count;
    assign stdout_wait_count = r_stdout_wait_count;
`else
    // Without performance counters the controller exposes only the pipeline controls.
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller.
// Two instances share stimulus: A uses 3 load-stall / 2 flush cycles, B the
// default 1 / 1. A behavioural model predicts both output sets each cycle;
// predictions and samples are queued and compared by each scenario task.
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       flush;
        logic       idex;
        logic       bubble;
        logic       exmem;
        logic [1:0] st;
    } outs_t;

    typedef struct packed {
        outs_t a;
        outs_t b;
    } pair_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1u;
        logic       rs2u;
        logic [4:0] rd;
        logic       rwe;
        logic       load;
        logic       redir;
        logic       sw;
        logic       busy;
    } stim_t;

    logic       clk;
    logic       reset;
    logic [4:0] idRs1, idRs2, exRd;
    logic       idRs1Used, idRs2Used, exRegWe, exIsLoad, exRedirect, exStdoutWe, stdoutBusy;
    logic       aPc, aIfid, aFlush, aIdex, aBubble, aExmem;
    logic       bPc, bIfid, bFlush, bIdex, bBubble, bExmem;
    logic [1:0] aSt, bSt;
`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [31:0] aLoadCnt, aFlushCnt, aStdoutCnt, bLoadCnt, bFlushCnt, bStdoutCnt;
`endif

    int checks = 0;
    int errors = 0;
    int mStA, mCntA, mStB, mCntB;
    pair_t expQ[$];
    pair_t obsQ[$];

    pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dutA (
        .clk(clk), .reset(reset),
        .id_rs1_address(idRs1), .id_rs2_address(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
        .ex_rd_address(exRd), .ex_reg_write_enable(exRegWe), .ex_is_load(exIsLoad),
        .ex_redirect(exRedirect), .ex_stdout_write_enable(exStdoutWe), .stdout_busy(stdoutBusy),
        .pc_write_enable(aPc), .if_id_write_enable(aIfid), .if_id_flush(aFlush),
        .id_ex_write_enable(aIdex), .id_ex_bubble(aBubble), .ex_mem_write_enable(aExmem),
        .ctrl_state(aSt)
`ifdef PIPELINE_PERF_COUNTERS_EN
        , .load_stall_count(aLoadCnt), .flush_count(aFlushCnt), .stdout_wait_count(aStdoutCnt)
`endif
    );

    pipeline_hazard_controller #(.LOAD_USE_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dutB (
        .clk(clk), .reset(reset),
        .id_rs1_address(idRs1), .id_rs2_address(idRs2),
        .id_rs1_used(idRs1Used), .id_rs2_used(idRs2Used),
        .ex_rd_address(exRd), .ex_reg_write_enable(exRegWe), .ex_is_load(exIsLoad),
        .ex_redirect(exRedirect), .ex_stdout_write_enable(exStdoutWe), .stdout_busy(stdoutBusy),
        .pc_write_enable(bPc), .if_id_write_enable(bIfid), .if_id_flush(bFlush),
        .id_ex_write_enable(bIdex), .id_ex_bubble(bBubble), .ex_mem_write_enable(bExmem),
        .ctrl_state(bSt)
`ifdef PIPELINE_PERF_COUNTERS_EN
        , .load_stall_count(bLoadCnt), .flush_count(bFlushCnt), .stdout_wait_count(bStdoutCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Reference behaviour of one controller instance for one cycle.
    function automatic void modelStep(input int lus, input int fc, input int st, input int cnt,
                                      input stim_t s, output outs_t o, output int nst, output int ncnt);
        logic lu;
        lu = s.load && s.rwe && (s.rd != 5'd0) &&
             ((s.rs1u && s.rs1 == s.rd) || (s.rs2u && s.rs2 == s.rd));
        nst  = st;
        ncnt = cnt;
        o    = '0;
        if (s.rst) begin
            nst  = 0;
            ncnt = 0;
            return;
        end
        case (st)
            0: begin
                if (s.sw && s.busy) begin
                    o = '{0, 0, 0, 0, 0, 0, 2'd0};
                    nst = 3;
                end else if (s.redir) begin
                    o = '{1, 1, 1, 1, 1, 1, 2'd0};
                    if (fc > 1) begin nst = 2; ncnt = fc - 2; end
                end else if (lu) begin
                    o = '{0, 0, 0, 1, 1, 1, 2'd0};
                    if (lus > 1) begin nst = 1; ncnt = lus - 2; end
                end else begin
                    o = '{1, 1, 0, 1, 0, 1, 2'd0};
                end
            end
            1: begin
                o = '{0, 0, 0, 1, 1, 1, 2'd1};
                if (cnt == 0) nst = 0; else ncnt = cnt - 1;
            end
            2: begin
                o = '{1, 1, 1, 1, 1, 1, 2'd2};
                if (cnt == 0) nst = 0; else ncnt = cnt - 1;
            end
            default: begin
                if (s.busy) o = '{0, 0, 0, 0, 0, 0, 2'd3};
                else begin
                    o = '{1, 1, 0, 1, 0, 1, 2'd3};
                    nst = 0;
                end
            end
        endcase
    endfunction

    // Drive one cycle of inputs (at posedge+1), queue predictions and samples.
    task automatic applyStimulus(input stim_t s);
        pair_t e, o;
        int nA, cA, nB, cB;
        reset      = s.rst;
        idRs1      = s.rs1;
        idRs2      = s.rs2;
        idRs1Used  = s.rs1u;
        idRs2Used  = s.rs2u;
        exRd       = s.rd;
        exRegWe    = s.rwe;
        exIsLoad   = s.load;
        exRedirect = s.redir;
        exStdoutWe = s.sw;
        stdoutBusy = s.busy;
        if (s.rst) begin
            mStA = 0; mCntA = 0; mStB = 0; mCntB = 0;
        end
        modelStep(3, 2, mStA, mCntA, s, e.a, nA, cA);
        modelStep(1, 1, mStB, mCntB, s, e.b, nB, cB);
        expQ.push_back(e);
        @(negedge clk);
        o.a = '{aPc, aIfid, aFlush, aIdex, aBubble, aExmem, aSt};
        o.b = '{bPc, bIfid, bFlush, bIdex, bBubble, bExmem, bSt};
        obsQ.push_back(o);
        @(posedge clk);
        mStA = nA; mCntA = cA; mStB = nB; mCntB = cB;
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.rst = 1'b1;
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs1u = 1'b1;
        applyStimulus(s);
        s.rst = 1'b0;
        applyStimulus(idleStim());
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL reset A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL reset B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs1u = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 4; i++) applyStimulus(idleStim());
        s = idleStim();
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd9; s.rs2 = 5'd9; s.rs2u = 1'b1; s.rs1 = 5'd3; s.rs1u = 1'b1;
        applyStimulus(s);
        s.redir = 1'b1; s.sw = 1'b1; s.busy = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL load_use A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL load_use B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_no_hazard();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs1u = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.rs2u = 1'b0; s.rs1 = 5'd7; s.rs1u = 1'b0;
        applyStimulus(s);
        s.rs1u = 1'b1; s.rwe = 1'b0;
        applyStimulus(s);
        s.rwe = 1'b1; s.load = 1'b0;
        applyStimulus(s);
        s.load = 1'b1; s.rs1 = 5'd6;
        applyStimulus(s);
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL no_hazard A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL no_hazard B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_redirect();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.redir = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idleStim());
        s = idleStim();
        s.redir = 1'b1; s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd4; s.rs1 = 5'd4; s.rs1u = 1'b1;
        applyStimulus(s);
        s.redir = 1'b0;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL redirect A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL redirect B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_stdout();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.sw = 1'b1; s.busy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(s);
        s.busy = 1'b0;
        applyStimulus(s);
        applyStimulus(idleStim());
        s = idleStim();
        s.sw = 1'b1; s.busy = 1'b1; s.redir = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.busy = 1'b1;
        applyStimulus(s);
        s.busy = 1'b0;
        applyStimulus(s);
        applyStimulus(idleStim());
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL stdout A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL stdout B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s;
        pair_t e, o;
        int n;
        s = idleStim();
        s.load = 1'b1; s.rwe = 1'b1; s.rd = 5'd12; s.rs1 = 5'd12; s.rs1u = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL reset_mid_stall A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL reset_mid_stall B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        pair_t e, o;
        int n;
        for (int i = 0; i < 80; i++) begin
            s       = idleStim();
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.rs1u  = 1'($urandom_range(0, 1));
            s.rs2u  = 1'($urandom_range(0, 1));
            s.rwe   = ($urandom_range(0, 3) != 0);
            s.load  = ($urandom_range(0, 2) != 0);
            s.redir = ($urandom_range(0, 5) == 0);
            s.sw    = ($urandom_range(0, 4) == 0);
            s.busy  = ($urandom_range(0, 1) == 0);
            applyStimulus(s);
        end
        n = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o.a !== e.a) begin errors++; $display("[TB] FAIL back_to_back A step %0d: got %b expected %b", n, o.a, e.a); end
            checks++;
            if (o.b !== e.b) begin errors++; $display("[TB] FAIL back_to_back B step %0d: got %b expected %b", n, o.b, e.b); end
            n++;
        end
    endtask

    // Scenario sequence; every task leaves the controllers idle in RUN.
    initial begin
        mStA = 0; mCntA = 0; mStB = 0; mCntB = 0;
        reset = 1'b1;
        idRs1 = '0; idRs2 = '0; exRd = '0;
        idRs1Used = 1'b0; idRs2Used = 1'b0; exRegWe = 1'b0; exIsLoad = 1'b0;
        exRedirect = 1'b0; exStdoutWe = 1'b0; stdoutBusy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_stdout();
        test_reset_mid_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage core.
- Inputs: ID-stage source registers, EX-stage control fields, the branch/jump redirect resolved in EX, and the stdout transmitter's busy flag.
- Outputs: write_enable for PC, IF/ID, ID/EX and EX/MEM; IF/ID flush; ID/EX bubble injection.
- Handles load-use stalls, taken-branch squashes and stdout back-pressure freezes.

Parameters:
LOAD_USE_STALL_CYCLES, 1, total bubble cycles inserted per load-use hazard (RAM read latency); legal range 1..15.
FLUSH_CYCLES, 1, cycles if_id_flush is held after a redirect (instruction-memory latency); legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_rs1_address  in  5  rs1 of instruction in ID
id_rs2_address  in  5  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd_address  in  5  rd of instruction in EX
ex_reg_write_enable  in  1  EX instruction writes a register
ex_is_load  in  1  EX reg_write_data_src selects RAM
ex_redirect  in  1  taken branch/jump resolved in EX
ex_stdout_write_enable  in  1  EX instruction writes stdout
stdout_busy  in  1  stdout transmitter cannot accept data
pc_write_enable  out  1  PC register update
if_id_write_enable  out  1  IF/ID capture
if_id_flush  out  1  IF/ID loads NOP
id_ex_write_enable  out  1  ID/EX capture
id_ex_bubble  out  1  ID/EX captures bubble (reg/ram/stdout write enables 0)
ex_mem_write_enable  out  1  EX/MEM capture
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- States (2-bit, registered):
  - RUN=0
  - LOAD_STALL=1
  - FLUSH=2
  - STDOUT_WAIT=3
- Down-counter cnt: 4 bits, registered.
- Outputs are combinational from state and inputs; state and cnt update on posedge clk.
- Reset (async, active-high): state=RUN, cnt=0.
  - While reset=1, all write enables=0 and flush/bubble=0; ctrl_state=0.
  - Reset deasserted mid-stall resumes in RUN with no residual stall.
- Hazard H = ex_is_load & ex_reg_write_enable & (ex_rd_address!=0) & ((id_rs1_used & id_rs1_address==ex_rd_address) | (id_rs2_used & id_rs2_address==ex_rd_address)).
- RUN, default: all write enables=1, flush=0, bubble=0.
- RUN, priority 1 (ex_stdout_write_enable & stdout_busy):
  - All four write enables=0.
  - Next state STDOUT_WAIT.
- RUN, priority 2 (ex_redirect):
  - if_id_flush=1, id_ex_bubble=1, all write enables=1 (the PC loads the target).
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-2.
- RUN, priority 3 (H):
  - pc_write_enable=0, if_id_write_enable=0, id_ex_bubble=1, id_ex/ex_mem write enables=1.
  - If LOAD_USE_STALL_CYCLES>1: next state LOAD_STALL, cnt=LOAD_USE_STALL_CYCLES-2.
- LOAD_STALL:
  - Same outputs as the RUN H case, regardless of H (EX now holds a bubble).
  - ex_redirect and stdout inputs are ignored.
  - cnt==0 -> RUN, else cnt-1.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, all write enables=1.
  - cnt==0 -> RUN, else cnt-1.
  - A new ex_redirect in FLUSH is ignored, since EX holds a bubble.
- STDOUT_WAIT:
  - While stdout_busy=1: all write enables=0.
  - When stdout_busy=0: all enables=1 that cycle, next state RUN.
- Simultaneous events: stdout freeze > redirect > load-use. A redirect together with H squashes the ID instruction, so no stall is taken.
- Latency: hazard detection and redirect are 0-cycle combinational responses. Total stall equals exactly the parameter value.

Optional Feature:
PIPELINE_PERF_COUNTERS_EN
- Defined:
  - Adds outputs load_stall_count, flush_count, stdout_wait_count (32 bits each).
  - Each counter increments once per cycle in which its cause holds pc_write_enable low or asserts flush.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - ctrl_state_t enum (RUN, LOAD_STALL, FLUSH, STDOUT_WAIT)
  - REG_ZERO=5'd0
  - STALL_CNT_W=4
- One combinational sub-module, load_use_detector, computes H. The FSM and output decode stay in the top module.

Test Plan:
- ex_is_load=1, ex_rd=5, ex_reg_we=1, id_rs1=5, rs1_used=1, LOAD_USE_STALL_CYCLES=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle all enables=1.
- Same hazard with LOAD_USE_STALL_CYCLES=3 and hazard inputs dropped after cycle 1 -> pc_we=0 for exactly 3 cycles; ctrl_state=1 in cycles 2-3.
- ex_rd=0 load, id_rs1=0 -> no stall; ex_rd=7 with rs2_used=0, id_rs2=7 -> no stall.
- ex_redirect=1 with FLUSH_CYCLES=2 -> if_id_flush=1 and bubble=1 for 2 cycles with pc_we=1; a simultaneous H causes no stall.
- ex_stdout_write_enable=1, stdout_busy=1 for 4 cycles -> all enables=0 for 4 cycles, state 3; busy=0 -> enables=1 and RUN next cycle. Stdout plus redirect in the same cycle -> freeze wins, flush=0.
- reset pulsed during LOAD_STALL (cnt=1) -> immediately all enables=0, ctrl_state=0; after release, enables=1 with no stall.
